// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: ALU function encodings and the supported major opcodes.
package decode_stage_pkg;

    typedef enum logic [6:0] {
        F7_ZERO = 7'b0000000,
        F7_NEG  = 7'b0100000
    } alu_funct7_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'b000,
        F3_XOR = 3'b100,
        F3_OR  = 3'b110,
        F3_AND = 3'b111
    } alu_funct3_e;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011
    } opcode_e;

    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two combinational read ports with write-first bypass, one write port.
module decode_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0][AW-1:0]        raddr_i,
    output logic [1:0][XLEN-1:0]      rdata_o,
    input  logic                      we_i,
    input  logic [AW-1:0]             waddr_i,
    input  logic [XLEN-1:0]           wdata_i
);

    // x0 has no storage; it is forced to zero on the read side.
    logic [XLEN-1:0] regs_reg [1:NREGS-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_reg[waddr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_comb begin
            rdata_o[gi] = '0;
            if (raddr_i[gi] != '0) begin
                if (we_i && (waddr_i == raddr_i[gi])) begin
                    rdata_o[gi] = wdata_i;
                end else begin
                    rdata_o[gi] = regs_reg[raddr_i[gi]];
                end
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode stage: register read, hazard scoreboard and registered outputs to execute.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  operand_1_o,
    output logic [XLEN-1:0]  operand_2_o,
    output alu_funct7_e      funct7_o,
    output alu_funct3_e      funct3_o,
    output logic [AW-1:0]    rd_o,
    output logic             rd_we_o,
    output logic             illegal_o,
    input  logic             wb_en_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i
);

    logic [6:0] opcode;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [2:0] f3_f;
    logic [6:0] f7_f;
    logic       is_op, is_opimm, is_neg;
    logic       idx_ok, legal, rd_we, hazard, accept;
    logic [AW-1:0] rd_a, rs1_a, rs2_a;

    assign opcode = instr_i[6:0];
    assign rd_f   = instr_i[11:7];
    assign f3_f   = instr_i[14:12];
    assign rs1_f  = instr_i[19:15];
    assign rs2_f  = instr_i[24:20];
    assign f7_f   = instr_i[31:25];
    assign rd_a   = rd_f[AW-1:0];
    assign rs1_a  = rs1_f[AW-1:0];
    assign rs2_a  = rs2_f[AW-1:0];

    assign is_op    = (opcode == OP);
    assign is_opimm = (opcode == OP_IMM);
    assign is_neg   = is_op && (f7_f == F7_NEG);

    // rs2 is only a register index for OP; for OP-IMM those bits are immediate.
    assign idx_ok = (int'(rd_f) < NREGS) && (int'(rs1_f) < NREGS)
                  && (!is_op || (int'(rs2_f) < NREGS));

    assign legal = (is_op || is_opimm) && funct3_supported(f3_f) && idx_ok
                 && (!is_op || (f7_f == F7_ZERO) || (is_neg && (f3_f == F3_ADD)));
    assign rd_we = legal && (rd_f != 5'd0);

    logic [NREGS-1:1] pending_reg, pending_next;
    logic [NREGS-1:0] pend_full;
    assign pend_full = {pending_reg, 1'b0};

    function automatic logic busy(input logic [AW-1:0] idx);
        return pend_full[idx] && !(wb_en_i && (wb_addr_i == idx));
    endfunction

    assign hazard = legal && (busy(rs1_a) || (is_op && busy(rs2_a)) || busy(rd_a));

    // Holds the stage not-ready until the first clock after reset is released.
    logic run_reg;
    logic ex_valid_reg;

    assign instr_ready_o = run_reg && (!ex_valid_reg || ex_ready_i) && !hazard;
    assign accept        = instr_valid_i && instr_ready_o;
    assign ex_valid_o    = ex_valid_reg;

    logic [1:0][AW-1:0]   rf_raddr;
    logic [1:0][XLEN-1:0] rf_rdata;
    assign rf_raddr[0] = rs1_a;
    assign rf_raddr[1] = rs2_a;

    decode_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata),
        .we_i    (wb_en_i),
        .waddr_i (wb_addr_i),
        .wdata_i (wb_data_i)
    );

    always_comb begin
        pending_next = pending_reg;
        if (wb_en_i && (wb_addr_i != '0)) begin
            pending_next[wb_addr_i] = 1'b0;
        end
        // Applied after the clear so a same-cycle set of the same register wins.
        if (accept && rd_we) begin
            pending_next[rd_a] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_reg      <= 1'b0;
            pending_reg  <= '0;
            ex_valid_reg <= 1'b0;
            operand_1_o  <= '0;
            operand_2_o  <= '0;
            funct7_o     <= F7_ZERO;
            funct3_o     <= F3_ADD;
            rd_o         <= '0;
            rd_we_o      <= 1'b0;
            illegal_o    <= 1'b0;
        end else begin
            run_reg     <= 1'b1;
            pending_reg <= pending_next;
            if (accept) begin
                ex_valid_reg <= 1'b1;
                operand_1_o  <= legal ? rf_rdata[0] : '0;
                if (!legal) begin
                    operand_2_o <= '0;
                end else if (is_op) begin
                    operand_2_o <= rf_rdata[1];
                end else begin
                    operand_2_o <= {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                end
                funct7_o  <= (legal && is_neg) ? F7_NEG : F7_ZERO;
                funct3_o  <= legal ? alu_funct3_e'(f3_f) : F3_ADD;
                rd_o      <= rd_a;
                rd_we_o   <= rd_we;
                illegal_o <= !legal;
            end else if (ex_ready_i) begin
                ex_valid_reg <= 1'b0;
            end
        end
    end

endmodule
